multiprocessor_array: RTL and testbench

- Parametrised successor of the grid multiprocessor: a WIDTH x HEIGHT array of cell_core instances sharing one SIMD instruction stream, holding per-cell state registers, and reducing per-cell diverge flags to a consensus.
- Adds a selectable boundary mode (torus or constant edge), a host-side raster-order load/dump streaming port with valid/ready handshakes, and a generation counter.
- Sits between the control unit (PC/SP/instruction sequencer) and the host/video loader.

---
 rtl/multiprocessor_array.sv | 192 +++++++++++++++++++
 tb/tb_multiprocessor_array.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiprocessor_array.sv
// SIMD cell array: WIDTH x HEIGHT cell_core instances sharing one instruction stream, with
// per-cell state registers, diverge consensus, raster load/dump port and generation counter.

// Combinational cell: computes the candidate next state from its neighbourhood.
module cell_core #(
  parameter int unsigned X               = 0,
  parameter int unsigned Y               = 0,
  parameter int unsigned REGISTER_LENGTH = 8
) (
  input  logic [11:0]                program_counter,
  input  logic [4:0]                 stack_pointer,
  input  logic [15:0]                instruction,
  input  logic                       execution_enable,
  input  logic [REGISTER_LENGTH-1:0] i01,
  input  logic [REGISTER_LENGTH-1:0] i10,
  input  logic [REGISTER_LENGTH-1:0] i11,
  input  logic [REGISTER_LENGTH-1:0] i12,
  input  logic [REGISTER_LENGTH-1:0] i21,
  output logic [REGISTER_LENGTH-1:0] next_state,
  output logic                       diverge
);
  localparam int unsigned RL = REGISTER_LENGTH;

  logic [RL-1:0] imm;
  logic [RL-1:0] result;

  assign imm = RL'(instruction[11:0]);

  // Opcode in the top nibble; unassigned opcodes hold the current value.
  always_comb begin
    result = i11;
    case (instruction[15:12])
      4'h1:    result = i01;
      4'h2:    result = i21;
      4'h3:    result = i10;
      4'h4:    result = i12;
      4'h5:    result = i01 + i21 + i10 + i12 + i11;
      4'h6:    result = i01 ^ i21 ^ i10 ^ i12;
      4'h7:    result = imm;
      4'h8:    result = i11 + imm;
      4'h9:    result = RL'(X + Y);
      4'hA:    result = RL'(program_counter);
      4'hB:    result = RL'(stack_pointer);
      default: result = i11;
    endcase
  end

  assign next_state = execution_enable ? result : i11;
  // A cell votes to diverge when its state matches the immediate field.
  assign diverge    = (i11 == imm);
endmodule

module multiprocessor_array #(
  parameter int unsigned                 WIDTH           = 10,
  parameter int unsigned                 HEIGHT          = 8,
  parameter int unsigned                 REGISTER_LENGTH = 8,
  parameter int unsigned                 BOUNDARY_MODE   = 0,
  parameter logic [REGISTER_LENGTH-1:0]  BOUNDARY_VALUE  = '0,
  parameter int unsigned                 GEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [11:0]                next_program_counter,
  input  logic [4:0]                 next_stack_pointer,
  input  logic [15:0]                instruction,
  input  logic                       execution_enable,
  output logic                       diverge_consensus,
  input  logic                       load_start,
  input  logic [REGISTER_LENGTH-1:0] load_data,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic                       dump_start,
  output logic [REGISTER_LENGTH-1:0] dump_data,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic                       busy,
  output logic [GEN_WIDTH-1:0]       generation
);
  localparam int unsigned N    = WIDTH * HEIGHT;
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned RL   = REGISTER_LENGTH;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDump} state_e;

  state_e        fsm_q;
  logic [IW-1:0] index_q;
  logic [RL-1:0] cell_q    [N];
  logic [RL-1:0] cell_next [N];
  logic [N-1:0]  cell_diverge;
  logic          cell_enable;

  // Starts take priority over a commit in the same cycle.
  assign cell_enable       = (fsm_q == StIdle) && execution_enable && !load_start && !dump_start;
  assign diverge_consensus = &cell_diverge;

  for (genvar y = 0; y < HEIGHT; y++) begin : g_row
    for (genvar x = 0; x < WIDTH; x++) begin : g_col
      localparam int unsigned YN = (y + HEIGHT - 1) % HEIGHT;
      localparam int unsigned YS = (y + 1) % HEIGHT;
      localparam int unsigned XW = (x + WIDTH - 1) % WIDTH;
      localparam int unsigned XE = (x + 1) % WIDTH;
      localparam bit CLAMP = (BOUNDARY_MODE == 1);

      logic [RL-1:0] n_north, n_south, n_west, n_east;

      assign n_north = (CLAMP && y == 0)          ? BOUNDARY_VALUE : cell_q[YN*WIDTH + x];
      assign n_south = (CLAMP && y == HEIGHT - 1) ? BOUNDARY_VALUE : cell_q[YS*WIDTH + x];
      assign n_west  = (CLAMP && x == 0)          ? BOUNDARY_VALUE : cell_q[y*WIDTH + XW];
      assign n_east  = (CLAMP && x == WIDTH - 1)  ? BOUNDARY_VALUE : cell_q[y*WIDTH + XE];

      cell_core #(
        .X               (x),
        .Y               (y),
        .REGISTER_LENGTH (RL)
      ) u_cell (
        .program_counter  (next_program_counter),
        .stack_pointer    (next_stack_pointer),
        .instruction      (instruction),
        .execution_enable (cell_enable),
        .i01              (n_north),
        .i10              (n_west),
        .i11              (cell_q[y*WIDTH + x]),
        .i12              (n_east),
        .i21              (n_south),
        .next_state       (cell_next[y*WIDTH + x]),
        .diverge          (cell_diverge[y*WIDTH + x])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= StIdle;
      index_q    <= '0;
      generation <= '0;
      load_ready <= 1'b0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      dump_data  <= '0;
      for (int i = 0; i < N; i++) cell_q[i] <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (load_start) begin
            fsm_q      <= StLoad;
            index_q    <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end else if (dump_start) begin
            fsm_q      <= StDump;
            index_q    <= '0;
            dump_valid <= 1'b1;
            busy       <= 1'b1;
            dump_data  <= cell_q[0];
          end else if (cell_enable) begin
            for (int i = 0; i < N; i++) cell_q[i] <= cell_next[i];
            generation <= generation + GEN_WIDTH'(1);
          end
        end
        StLoad: begin
          if (load_valid) begin
            cell_q[index_q] <= load_data;
            if (index_q == LAST) begin
              fsm_q      <= StIdle;
              index_q    <= '0;
              generation <= '0;
              load_ready <= 1'b0;
              busy       <= 1'b0;
            end else begin
              index_q <= index_q + IW'(1);
            end
          end
        end
        StDump: begin
          if (dump_ready) begin
            if (index_q == LAST) begin
              fsm_q      <= StIdle;
              index_q    <= '0;
              dump_valid <= 1'b0;
              busy       <= 1'b0;
            end else begin
              index_q   <= index_q + IW'(1);
              dump_data <= cell_q[index_q + IW'(1)];
            end
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_multiprocessor_array.sv
// Scoreboard bench: two 4x3 arrays (torus and constant-edge) driven in lockstep against a grid model.
module tb_multiprocessor_array;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] next_program_counter = '0;
  logic [4:0]  next_stack_pointer = '0;
  logic [15:0] instruction = '0;
  logic        execution_enable = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_valid = 1'b0;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;

  logic        d0_div, d1_div, d0_lrdy, d1_lrdy, d0_dval, d1_dval, d0_busy, d1_busy;
  logic [7:0]  d0_ddat, d1_ddat;
  logic [15:0] d0_gen, d1_gen;

  int errors = 0;
  int checks = 0;

  logic [7:0]  g [2][N];
  logic [15:0] mgen = '0;
  logic [7:0]  lv [N];
  logic [7:0]  exp0 [$];
  logic [7:0]  exp1 [$];

  always #5 clk = ~clk;

  multiprocessor_array #(
    .WIDTH (W), .HEIGHT (H), .REGISTER_LENGTH (8), .BOUNDARY_MODE (0),
    .BOUNDARY_VALUE (8'h55), .GEN_WIDTH (16)
  ) d0 (
    .clk (clk), .rst (rst), .next_program_counter (next_program_counter),
    .next_stack_pointer (next_stack_pointer), .instruction (instruction),
    .execution_enable (execution_enable), .diverge_consensus (d0_div),
    .load_start (load_start), .load_data (load_data), .load_valid (load_valid),
    .load_ready (d0_lrdy), .dump_start (dump_start), .dump_data (d0_ddat),
    .dump_valid (d0_dval), .dump_ready (dump_ready), .busy (d0_busy), .generation (d0_gen)
  );

  multiprocessor_array #(
    .WIDTH (W), .HEIGHT (H), .REGISTER_LENGTH (8), .BOUNDARY_MODE (1),
    .BOUNDARY_VALUE (8'h55), .GEN_WIDTH (16)
  ) d1 (
    .clk (clk), .rst (rst), .next_program_counter (next_program_counter),
    .next_stack_pointer (next_stack_pointer), .instruction (instruction),
    .execution_enable (execution_enable), .diverge_consensus (d1_div),
    .load_start (load_start), .load_data (load_data), .load_valid (load_valid),
    .load_ready (d1_lrdy), .dump_start (dump_start), .dump_data (d1_ddat),
    .dump_valid (d1_dval), .dump_ready (dump_ready), .busy (d1_busy), .generation (d1_gen)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no completion expected completion", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] nbr(input int m, input int x, input int y);
    if (m == 1 && (x < 0 || x >= W || y < 0 || y >= H)) return 8'h55;
    return g[m][((y + H) % H) * W + ((x + W) % W)];
  endfunction

  function automatic logic model_consensus(input int m, input logic [7:0] imm);
    for (int i = 0; i < N; i++) if (g[m][i] != imm) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_exec(input logic [15:0] ins, input logic [11:0] pc, input logic [4:0] sp);
    logic [7:0] nx [2][N];
    logic [7:0] imm, self_v, n, s, w, e, r;
    imm = ins[7:0];
    for (int m = 0; m < 2; m++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          self_v = g[m][y*W + x];
          n = nbr(m, x, y - 1);
          s = nbr(m, x, y + 1);
          w = nbr(m, x - 1, y);
          e = nbr(m, x + 1, y);
          case (ins[15:12])
            4'h1: r = n;
            4'h2: r = s;
            4'h3: r = w;
            4'h4: r = e;
            4'h5: r = n + s + w + e + self_v;
            4'h6: r = n ^ s ^ w ^ e;
            4'h7: r = imm;
            4'h8: r = self_v + imm;
            4'h9: r = 8'(x + y);
            4'hA: r = pc[7:0];
            4'hB: r = {3'b000, sp};
            default: r = self_v;
          endcase
          nx[m][y*W + x] = r;
        end
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) g[m][i] = nx[m][i];
    mgen = mgen + 16'd1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) g[m][i] = 8'h00;
    mgen = '0;
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic exec_step(input logic [15:0] ins);
    logic [11:0] pc;
    logic [4:0]  sp;
    pc = 12'($urandom);
    sp = 5'($urandom);
    instruction = ins;
    next_program_counter = pc;
    next_stack_pointer = sp;
    execution_enable = 1'b1;
    #1;
    chk("consensus_torus", 32'(d0_div), 32'(model_consensus(0, ins[7:0])));
    chk("consensus_edge", 32'(d1_div), 32'(model_consensus(1, ins[7:0])));
    step();
    execution_enable = 1'b0;
    model_exec(ins, pc, sp);
    chk("generation_torus", 32'(d0_gen), 32'(mgen));
    chk("generation_edge", 32'(d1_gen), 32'(mgen));
  endtask

  task automatic load_beats(input bit gaps, input int nb);
    int i = 0;
    int cyc = 0;
    while (i < nb && cyc < 200) begin
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data = load_valid ? lv[i] : 8'($urandom);
      if (d0_lrdy && load_valid) i++;
      step();
      cyc++;
    end
    load_valid = 1'b0;
    if (i < nb) timeout_fail("load_beats");
  endtask

  task automatic finish_load_checks();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) g[m][i] = lv[i];
    mgen = '0;
    chk("load_busy_torus", 32'(d0_busy), 32'd0);
    chk("load_busy_edge", 32'(d1_busy), 32'd0);
    chk("load_ready_after", 32'(d0_lrdy), 32'd0);
    chk("load_gen", 32'(d0_gen), 32'd0);
  endtask

  task automatic run_load(input bit gaps);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_ready_in_load", 32'(d1_lrdy), 32'd1);
    load_beats(gaps, N);
    finish_load_checks();
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at index 5, 3: exec requested
  task automatic run_dump(input int mode);
    int beats = 0;
    int cyc = 0;
    int stall = 0;
    for (int i = 0; i < N; i++) begin
      exp0.push_back(g[0][i]);
      exp1.push_back(g[1][i]);
    end
    dump_start = 1'b1;
    if (mode == 3) begin
      execution_enable = 1'b1;
      instruction = 16'h7033;
    end
    step();
    dump_start = 1'b0;
    chk("dump_busy", 32'(d0_busy), 32'd1);
    while (beats < N && cyc < 200) begin
      if (mode == 1) dump_ready = ($urandom_range(0, 1) == 1);
      else if (mode == 2 && beats == 5 && stall < 3) begin
        dump_ready = 1'b0;
        stall++;
      end else dump_ready = 1'b1;
      if (d0_dval && dump_ready) beats++;
      step();
      cyc++;
    end
    dump_ready = 1'b0;
    execution_enable = 1'b0;
    if (beats < N) timeout_fail("dump_beats");
    chk("dump_valid_after_torus", 32'(d0_dval), 32'd0);
    chk("dump_valid_after_edge", 32'(d1_dval), 32'd0);
    chk("dump_busy_after", 32'(d1_busy), 32'd0);
    chk("dump_queue_drained", 32'(exp0.size() + exp1.size()), 32'd0);
    chk("dump_gen_unchanged", 32'(d0_gen), 32'(mgen));
    exp0.delete();
    exp1.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (d0_dval) begin
        if (exp0.size() == 0) chk("dump_unexpected_torus", 32'(d0_ddat), 32'hFFFF_FFFF);
        else begin
          chk("dump_data_torus", 32'(d0_ddat), 32'(exp0[0]));
          if (dump_ready) void'(exp0.pop_front());
        end
      end
      if (d1_dval) begin
        if (exp1.size() == 0) chk("dump_unexpected_edge", 32'(d1_ddat), 32'hFFFF_FFFF);
        else begin
          chk("dump_data_edge", 32'(d1_ddat), 32'(exp1[0]));
          if (dump_ready) void'(exp1.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", 32'(d0_busy | d1_busy), 32'd0);
    chk("reset_gen", 32'(d0_gen), 32'd0);
    chk("reset_load_ready", 32'(d0_lrdy | d1_lrdy), 32'd0);
    chk("reset_dump_valid", 32'(d0_dval | d1_dval), 32'd0);
    chk("reset_dump_data", 32'(d0_ddat), 32'd0);
    run_dump(0);

    // Round trip 1..12, then stalled dump.
    for (int i = 0; i < N; i++) lv[i] = 8'(i + 1);
    run_load(1'b0);
    run_dump(0);
    run_dump(2);

    // Random values with load_valid gaps, random backpressure.
    for (int i = 0; i < N; i++) lv[i] = 8'($urandom);
    run_load(1'b1);
    run_dump(1);

    // Boundary: (0,0)=0xAA, north copy.
    for (int i = 0; i < N; i++) lv[i] = 8'h00;
    lv[0] = 8'hAA;
    run_load(1'b0);
    exec_step(16'h1000);
    chk("north_copy_torus_cell01", 32'(g[0][W]), 32'hAA);
    run_dump(0);

    // Random instruction stream.
    for (int i = 0; i < N; i++) lv[i] = 8'($urandom);
    run_load(1'b1);
    for (int k = 0; k < 30; k++) exec_step({4'($urandom_range(0, 15)), 12'($urandom)});
    run_dump(1);
    exec_step(16'h703C);
    exec_step(16'h003C);
    run_dump(0);

    // Priority: all three requests together.
    exec_step(16'h8005);
    load_start = 1'b1;
    dump_start = 1'b1;
    execution_enable = 1'b1;
    instruction = 16'h7077;
    step();
    load_start = 1'b0;
    dump_start = 1'b0;
    execution_enable = 1'b0;
    chk("prio_busy", 32'(d0_busy), 32'd1);
    chk("prio_load_ready", 32'(d0_lrdy), 32'd1);
    chk("prio_dump_valid", 32'(d0_dval), 32'd0);
    chk("prio_gen", 32'(d0_gen), 32'(mgen));
    for (int i = 0; i < N; i++) lv[i] = 8'($urandom);
    load_beats(1'b0, N);
    finish_load_checks();
    exec_step(16'h5000);
    run_dump(3);

    // Reset mid-load after 5 beats.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_beats(1'b0, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("midload_busy", 32'(d0_busy | d1_busy), 32'd0);
    chk("midload_load_ready", 32'(d0_lrdy), 32'd0);
    chk("midload_gen", 32'(d1_gen), 32'd0);
    run_dump(0);

    // Generation wrap.
    instruction = 16'h0000;
    execution_enable = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    execution_enable = 1'b0;
    mgen = 16'hFFFF;
    chk("gen_max", 32'(d0_gen), 32'hFFFF);
    exec_step(16'h0000);
    chk("gen_wrapped", 32'(d0_gen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
